// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: register-file write-port arbiter.
//   Merges pipeline writebacks (highest priority) with long-latency unit
//   results buffered in a DEPTH-entry FIFO into one registered write stream.
// Ports:
//   clk_i, rst_n_i                 clock / async active-low reset
//   pipe_we_d/reg_d/data_d         same-cycle pipeline writeback
//   lu_valid_d/ready_q/reg_d/data_d  long-latency handshake into the FIFO
//   chk_reg_d -> chk_pend          hazard query: write pending for a register
//   stall_req_q                    ask the pipeline to back off (starved/full)
//   regwrite_q/write_reg_q/write_data_q  register-file write port
module wb_write_arbiter #(
  parameter int WIDTH        = 32,
  parameter int R_WIDTH      = 5,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               pipe_we_d,
  input  logic [R_WIDTH-1:0] pipe_reg_d,
  input  logic [WIDTH-1:0]   pipe_data_d,
  input  logic               lu_valid_d,
  output logic               lu_ready_q,
  input  logic [R_WIDTH-1:0] lu_reg_d,
  input  logic [WIDTH-1:0]   lu_data_d,
  input  logic [R_WIDTH-1:0] chk_reg_d,
  output logic               chk_pend,
  output logic               stall_req_q,
  output logic               regwrite_q,
  output logic [R_WIDTH-1:0] write_reg_q,
  output logic [WIDTH-1:0]   write_data_q
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [R_WIDTH-1:0] rd;
    logic [WIDTH-1:0]   data;
  } wb_req_t;

  wb_req_t        mem [DEPTH];
  logic [AW-1:0]  rd_ptr, wr_ptr;
  logic [CW-1:0]  count;
  logic [SW-1:0]  starve, starve_nxt;
  logic           pipe_win, empty, pop, push, stall_nxt;
  logic [DEPTH-1:0] hit;

  // Ready comes straight from the registered count, so a same-cycle pop
  // never opens the FIFO early.
  assign lu_ready_q = (count != CW'(DEPTH));

  always_comb begin
    pipe_win   = pipe_we_d && (pipe_reg_d != '0);
    empty      = (count == '0);
    pop        = !pipe_win && !empty;
    // r0 results are consumed by the handshake but never stored.
    push       = lu_valid_d && lu_ready_q && (lu_reg_d != '0);
    starve_nxt = '0;
    if (pipe_win && !empty)
      starve_nxt = (starve == SW'(STARVE_LIMIT)) ? starve : starve + SW'(1);
    // A pop always relieves the stall on the following cycle.
    stall_nxt  = !pop && ((starve_nxt == SW'(STARVE_LIMIT)) ||
                          ((count == CW'(DEPTH)) && lu_valid_d));
  end

  // Slot i is live when its distance from the head is below count;
  // pointer subtraction wraps for free since DEPTH is a power of 2.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      logic [AW-1:0] ofs;
      ofs    = AW'(i) - rd_ptr;
      hit[i] = (CW'(ofs) < count) && (mem[i].rd == chk_reg_d);
    end
    chk_pend = (chk_reg_d != '0) &&
               ((|hit) || (regwrite_q && (write_reg_q == chk_reg_d)));
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= '{rd: lu_reg_d, data: lu_data_d};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      starve       <= '0;
      stall_req_q  <= 1'b0;
      regwrite_q   <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      starve      <= starve_nxt;
      stall_req_q <= stall_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      regwrite_q <= pipe_win || pop;
      if (pipe_win) begin
        write_reg_q  <= pipe_reg_d;
        write_data_q <= pipe_data_d;
      end else if (pop) begin
        write_reg_q  <= mem[rd_ptr].rd;
        write_data_q <= mem[rd_ptr].data;
      end
    end
  end
endmodule
